vx_tcu_drl_norm_round: RTL and testbench

VX_TCU_DRL_NORM_ROUND -- requirements
Module: VX_tcu_drl_norm_round

---
 rtl/vx_tcu_pkg.sv | 21 ++
 rtl/vx_tcu_drl_lzc.sv | 21 ++
 rtl/vx_tcu_drl_norm_round.sv | 204 ++++++++++++++++++++
 tb/tb_vx_tcu_drl_norm_round.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_pkg.sv
// Shared binary32 constants, result flag layout and rounding helper for the
// tensor-core normalise/round datapath.
package vx_tcu_pkg;

  localparam int F32_BIAS    = 127;
  localparam int F32_EXP_MAX = 254;
  localparam int F32_SIG_W   = 24;

  // Packed so that a cast to logic [2:0] gives {overflow, underflow, inexact}.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } tcu_flags_t;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_round_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/vx_tcu_drl_lzc.sv
// Leading-one detector: reports the bit index of the most significant set bit
// of data_in, and whether data_in is all zero (pos is 0 in that case).
module vx_tcu_drl_lzc #(
  parameter int WIDTH = 32,
  parameter int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [POS_W-1:0] pos,
  output logic             all_zero
);

  // Scan upward so the last set bit seen is the leading one.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos = data_in[i] ? POS_W'(i) : pos;
    end
    all_zero = (data_in == '0);
  end

endmodule

// File: rtl/vx_tcu_drl_norm_round.sv
// Normalise and round a signed fixed-point mantissa sum to IEEE binary32.
// Three elastic stages: sign/magnitude, leading-one normalise, round/pack.
// Optional feature macro: TCU_NORM_SUBNORMAL_EN (gradual underflow instead of
// flush-to-zero when the biased exponent drops below 1).
module vx_tcu_drl_norm_round
  import vx_tcu_pkg::*;
#(
  parameter int SUM_W  = 32,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [SUM_W-1:0] sum,
  input  logic [EXP_W-1:0] max_exp,
  input  logic             sticky_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [31:0]      result,
  output logic [2:0]       flags
);

  localparam int E_W   = EXP_W + 3;
  localparam int POS_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  // Normalised magnitude padded so significand, guard and sticky always exist.
  localparam int EXT_W = SUM_W + F32_SIG_W + 2;
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);
  localparam logic signed [E_W-1:0] E_MAX = E_W'(F32_EXP_MAX);

  logic ld1_s, ld2_s, ld3_s;

  logic             v1_d, v1_q, sign1_d, sign1_q, zero1_d, zero1_q, sticky1_d, sticky1_q;
  logic [SUM_W-1:0] mag1_d, mag1_q;
  logic [EXP_W-1:0] exp1_d, exp1_q;

  logic                  v2_d, v2_q, sign2_d, sign2_q, zero2_d, zero2_q, sticky2_d, sticky2_q;
  logic [SUM_W-1:0]      norm2_d, norm2_q;
  logic signed [E_W-1:0] e2_d, e2_q;

  logic        valid_out_d, valid_out_q;
  logic [31:0] result_d, result_q;
  tcu_flags_t  flags_d, flags_q;

  logic [POS_W-1:0] lzc_pos_s;
  logic             lzc_zero_s;
  logic [POS_W-1:0] shamt_s;

  logic [EXT_W-1:0]      ext_s;
  logic [F32_SIG_W-1:0]  sig_s, r_sig_s;
  logic                  guard_s, sticky_s, r_guard_s, r_sticky_s, tiny_s, up_s;
  logic [F32_SIG_W:0]    rnd_s;
  logic signed [E_W-1:0] e_rnd_s;
  logic [31:0]           res_s;
  tcu_flags_t            flags_s;
`ifdef TCU_NORM_SUBNORMAL_EN
  localparam logic signed [E_W-1:0] E_SAT = E_W'(25);
  logic signed [E_W-1:0]   sh_full_s;
  logic [4:0]              sh_s;
  logic [F32_SIG_W+25:0]   sub_vec_s;
`endif

  vx_tcu_drl_lzc #(.WIDTH(SUM_W), .POS_W(POS_W)) u_lzc (
    .data_in  (mag1_q),
    .pos      (lzc_pos_s),
    .all_zero (lzc_zero_s)
  );

  // Elastic load enables: a stage loads when empty or when its successor loads.
  always_comb begin
    ld3_s = ~valid_out_q | ready_out;
    ld2_s = ~v2_q | ld3_s;
    ld1_s = ~v1_q | ld2_s;
  end

  assign ready_in = ld1_s;

  // Stage 1: split the two's-complement sum into sign and magnitude.
  always_comb begin
    v1_d = v1_q; sign1_d = sign1_q; zero1_d = zero1_q; sticky1_d = sticky1_q;
    mag1_d = mag1_q; exp1_d = exp1_q;
    if (ld1_s) begin
      v1_d      = valid_in;
      sign1_d   = sum[SUM_W-1];
      mag1_d    = sum[SUM_W-1] ? (~sum + SUM_W'(1)) : sum;
      zero1_d   = (sum == '0);
      exp1_d    = max_exp;
      sticky1_d = sticky_in;
    end else begin
      v1_d = v1_q;
    end
  end

  // Stage 2: shift the leading one into the MSB and form the biased exponent.
  always_comb begin
    shamt_s = POS_W'(SUM_W - 1) - lzc_pos_s;
    v2_d = v2_q; sign2_d = sign2_q; zero2_d = zero2_q; sticky2_d = sticky2_q;
    norm2_d = norm2_q; e2_d = e2_q;
    if (ld2_s) begin
      v2_d      = v1_q;
      sign2_d   = sign1_q;
      zero2_d   = zero1_q | lzc_zero_s;
      sticky2_d = sticky1_q;
      norm2_d   = mag1_q << shamt_s;
      e2_d      = E_W'(exp1_q) + E_W'(lzc_pos_s) - E_W'(FRAC_W);
    end else begin
      v2_d = v2_q;
    end
  end

  // Stage 3 datapath: extract significand/guard/sticky, round, pack binary32.
  always_comb begin
    ext_s      = {norm2_q, {(F32_SIG_W + 2){1'b0}}};
    sig_s      = ext_s[EXT_W-1 -: F32_SIG_W];
    guard_s    = ext_s[SUM_W+1];
    sticky_s   = (|ext_s[SUM_W:0]) | sticky2_q;
    tiny_s     = (e2_q < E_ONE);
    r_sig_s    = sig_s;
    r_guard_s  = guard_s;
    r_sticky_s = sticky_s;
`ifdef TCU_NORM_SUBNORMAL_EN
    // Denormalise by 1-e; beyond 25 places every bit is sticky anyway.
    sh_full_s = E_ONE - e2_q;
    sh_s      = (sh_full_s > E_SAT) ? 5'd25 : sh_full_s[4:0];
    sub_vec_s = {sig_s, guard_s, 25'd0} >> sh_s;
    if (tiny_s) begin
      r_sig_s    = sub_vec_s[F32_SIG_W+25:26];
      r_guard_s  = sub_vec_s[25];
      r_sticky_s = (|sub_vec_s[24:0]) | sticky_s;
    end else begin
      r_sig_s = sig_s;
    end
`endif
    up_s    = rne_round_up(r_sig_s[0], r_guard_s, r_sticky_s);
    rnd_s   = {1'b0, r_sig_s} + (F32_SIG_W + 1)'(up_s);
    e_rnd_s = e2_q + E_W'(rnd_s[F32_SIG_W]);
    res_s   = 32'd0;
    flags_s = '0;
    if (zero2_q) begin
      res_s   = 32'd0;
      flags_s = '0;
    end else if (tiny_s) begin
`ifdef TCU_NORM_SUBNORMAL_EN
      // A round-up into bit 23 naturally yields the smallest normal.
      res_s             = {sign2_q, 7'd0, rnd_s[F32_SIG_W-1:0]};
      flags_s.inexact   = r_guard_s | r_sticky_s;
      flags_s.underflow = r_guard_s | r_sticky_s;
`else
      res_s             = {sign2_q, 31'd0};
      flags_s.inexact   = 1'b1;
      flags_s.underflow = 1'b1;
`endif
    end else if (e_rnd_s > E_MAX) begin
      res_s            = {sign2_q, 8'hFF, 23'd0};
      flags_s.overflow = 1'b1;
      flags_s.inexact  = 1'b1;
    end else begin
      // On carry-out the significand became 1.0, so the fraction field is zero.
      res_s           = {sign2_q, 8'(e_rnd_s), rnd_s[F32_SIG_W] ? 23'd0 : rnd_s[22:0]};
      flags_s.inexact = r_guard_s | r_sticky_s;
    end
  end

  // Stage 3 register: output holds while stalled by the consumer.
  always_comb begin
    valid_out_d = valid_out_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (ld3_s) begin
      valid_out_d = v2_q;
      if (v2_q) begin
        result_d = res_s;
        flags_d  = flags_s;
      end else begin
        result_d = result_q;
      end
    end else begin
      valid_out_d = valid_out_q;
    end
  end

  // Pipeline state; reset discards every in-flight beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; zero1_q <= 1'b0; sticky1_q <= 1'b0;
      mag1_q <= '0; exp1_q <= '0;
      v2_q <= 1'b0; sign2_q <= 1'b0; zero2_q <= 1'b0; sticky2_q <= 1'b0;
      norm2_q <= '0; e2_q <= '0;
      valid_out_q <= 1'b0; result_q <= 32'd0; flags_q <= '0;
    end else begin
      v1_q <= v1_d; sign1_q <= sign1_d; zero1_q <= zero1_d; sticky1_q <= sticky1_d;
      mag1_q <= mag1_d; exp1_q <= exp1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; zero2_q <= zero2_d; sticky2_q <= sticky2_d;
      norm2_q <= norm2_d; e2_q <= e2_d;
      valid_out_q <= valid_out_d; result_q <= result_d; flags_q <= flags_d;
    end
  end

  assign valid_out = valid_out_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_vx_tcu_drl_norm_round.sv
// Self-checking bench for vx_tcu_drl_norm_round (default parameters).
module tb_vx_tcu_drl_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, ready_in, sticky_in, valid_out, ready_out;
  logic [31:0] sum, result;
  logic [7:0]  max_exp;
  logic [2:0]  flags;

  int compared   = 0;
  int mismatched = 0;
  logic [34:0] exp_q[$];

  vx_tcu_drl_norm_round dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .sum(sum), .max_exp(max_exp), .sticky_in(sticky_in),
    .valid_out(valid_out), .ready_out(ready_out), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Round mag * 2^-sh to an integer, nearest-even; sticky is an extra
  // infinitesimal below the retained bits.
  function automatic void rne_shift(input longint unsigned mag, input int sh, input bit st,
                                    output longint unsigned q, output bit inx);
    longint unsigned rem, half;
    if (sh <= 0) begin
      q = mag << (-sh);
      inx = st;
    end else begin
      q = mag >> sh;
      rem = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      inx = (rem != 0) || st;
      if (rem > half || (rem == half && (st || q[0]))) q = q + 1;
    end
  endfunction

  // Reference: value = sum * 2^(me - 151); returns {ovf, unf, inx, result}.
  function automatic logic [34:0] ref_model(input logic [31:0] s, input logic [7:0] me, input bit st);
    longint sv;
    longint unsigned mag, q;
    int p, e;
    bit sgn, inx;
    if (s == 32'd0) return 35'd0;
    sgn = s[31];
    sv  = longint'($signed(s));
    mag = sgn ? -sv : sv;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = int'(me) + p - 24;
    if (e < 1) begin
`ifdef TCU_NORM_SUBNORMAL_EN
      rne_shift(mag, 2 - int'(me), st, q, inx);
      return {1'b0, inx, inx, sgn, q[30:0]};
`else
      return {3'b011, sgn, 31'd0};
`endif
    end
    rne_shift(mag, p - 23, st, q, inx);
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
    if (e > 254) return {3'b101, sgn, 8'hFF, 23'd0};
    return {2'b00, inx, sgn, 8'(e), q[22:0]};
  endfunction

  // Drive inputs after the falling edge, then sample outputs mid-cycle.
  task automatic step(input logic vi, input logic [31:0] s, input logic [7:0] me, input logic st,
                      input logic ro, output logic ri, output logic vo,
                      output logic [31:0] res, output logic [2:0] fl);
    @(negedge clk);
    valid_in = vi; sum = s; max_exp = me; sticky_in = st; ready_out = ro;
    #1;
    ri = ready_in; vo = valid_out; res = result; fl = flags;
  endtask

  task automatic test_reset();
    valid_in = 1'b0; sum = 32'd0; max_exp = 8'd0; sticky_in = 1'b0; ready_out = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    compared++;
    if ({valid_out, ready_in, result, flags} !== {1'b0, 1'b1, 32'd0, 3'd0}) begin
      mismatched++;
      $display("FAIL reset_state: got vo=%b ri=%b res=%h fl=%b, want vo=0 ri=1 res=0 fl=000",
               valid_out, ready_in, result, flags);
    end
  endtask

  task automatic test_directed();
    logic [31:0] d_sum[11]  = '{32'h01000000, 32'hFF000000, 32'h00000000, 32'h02000002,
                                32'h02000006, 32'h02000002, 32'h7FFFFFFF, 32'h00000001,
                                32'h01FFFFFF, 32'h80000000, 32'h01FFFFFF};
    logic [7:0]  d_exp[11]  = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127,
                                8'd254, 8'd1, 8'd127, 8'd120, 8'd254};
    logic        d_st[11]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // 0x02000006 is 2 + 1.5 ulp: the tie goes to the even neighbour 0x40000002.
    logic [31:0] d_res[11]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h40000000,
                                32'h40000002, 32'h40000001, 32'h7F800000, 32'h00000000,
                                32'h40000000, 32'hBF800000, 32'h7F800000};
    logic [2:0]  d_fl[11]   = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b001,
                                3'b101, 3'b011, 3'b001, 3'b000, 3'b101};
    logic ri, vo;
    logic [31:0] res;
    logic [2:0] fl;
    int lat;
    for (int i = 0; i < 11; i++) begin
      step(1'b1, d_sum[i], d_exp[i], d_st[i], 1'b1, ri, vo, res, fl);
      compared++;
      if (ri !== 1'b1) begin
        mismatched++;
        $display("FAIL dir_accept[%0d]: ready_in=%b want 1", i, ri);
      end
      lat = 0;
      vo = 1'b0;
      while (!vo && lat < 8) begin
        step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, ri, vo, res, fl);
        lat++;
      end
      compared++;
      if (lat !== 3) begin
        mismatched++;
        $display("FAIL dir_latency[%0d]: got %0d cycles want 3", i, lat);
      end
      compared++;
      if ({res, fl} !== {d_res[i], d_fl[i]}) begin
        mismatched++;
        $display("FAIL dir_value[%0d]: got %h/%b want %h/%b", i, res, fl, d_res[i], d_fl[i]);
      end
    end
    repeat (2) step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, ri, vo, res, fl);
  endtask

  task automatic test_random();
    logic ri, vo, vi, ro, st;
    logic [31:0] res, s;
    logic [7:0] me;
    logic [2:0] fl;
    int guard_cnt;
    for (int c = 0; c < 400; c++) begin
      vi = ($urandom_range(0, 3) != 0);
      ro = ($urandom_range(0, 9) < 7);
      s  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) s = -s;
      if ($urandom_range(0, 15) == 0) s = 32'd0;
      me = 8'($urandom_range(0, 255));
      st = $urandom_range(0, 1);
      step(vi, s, me, st, ro, ri, vo, res, fl);
      compared++;
      if (ri !== !(exp_q.size() == 3 && !ro)) begin
        mismatched++;
        $display("FAIL rnd_ready_in: got %b with %0d in flight ro=%b", ri, exp_q.size(), ro);
      end
      if (vo) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rnd_spurious: got %h/%b want no output", res, fl);
        end else if ({fl, res} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL rnd_value: got %h/%b want %h/%b", res, fl, exp_q[0][31:0], exp_q[0][34:32]);
        end
        if (ro && exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (vi && ri) exp_q.push_back(ref_model(s, me, st));
    end
    guard_cnt = 0;
    while (exp_q.size() != 0 && guard_cnt < 20) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, ri, vo, res, fl);
      if (vo) begin
        compared++;
        if ({fl, res} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL rnd_drain: got %h/%b want %h/%b", res, fl, exp_q[0][31:0], exp_q[0][34:32]);
        end
        void'(exp_q.pop_front());
      end
      guard_cnt++;
    end
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_lost: %0d beats never emerged, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_sum[8];
    logic [7:0]  b_exp[8];
    logic ri, vo, ro;
    logic [31:0] res;
    logic [2:0] fl;
    int sent, got;
    for (int i = 0; i < 8; i++) begin
      b_sum[i] = $urandom >> $urandom_range(4, 12);
      b_exp[i] = 8'($urandom_range(100, 150));
    end
    sent = 0;
    got  = 0;
    for (int c = 0; c < 30; c++) begin
      ro = !(c >= 2 && c <= 6);
      step(sent < 8, (sent < 8) ? b_sum[sent % 8] : 32'd0, (sent < 8) ? b_exp[sent % 8] : 8'd0,
           1'b0, ro, ri, vo, res, fl);
      compared++;
      if (ri !== !(exp_q.size() == 3 && !ro)) begin
        mismatched++;
        $display("FAIL b2b_ready_in[%0d]: got %b with %0d in flight ro=%b", c, ri, exp_q.size(), ro);
      end
      if (vo) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL b2b_spurious[%0d]: got %h want no output", c, res);
        end else if ({fl, res} !== exp_q[0]) begin
          mismatched++;
          $display("FAIL b2b_value[%0d]: got %h/%b want %h/%b", c, res, fl, exp_q[0][31:0], exp_q[0][34:32]);
        end
        if (ro && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          got++;
        end
      end
      if (sent < 8 && ri) begin
        exp_q.push_back(ref_model(b_sum[sent], b_exp[sent], 1'b0));
        sent++;
      end
    end
    compared++;
    if (got !== 8 || sent !== 8) begin
      mismatched++;
      $display("FAIL b2b_count: sent %0d received %0d want 8/8", sent, got);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    logic ri, vo;
    logic [31:0] res;
    logic [2:0] fl;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h01000000 + 32'(i), 8'd127, 1'b0, 1'b0, ri, vo, res, fl);
    valid_in = 1'b0;
    @(posedge clk);
    #2;
    compared++;
    if (valid_out !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_fill: valid_out=%b want 1 before reset", valid_out);
    end
    reset = 1'b1;
    #1;
    compared++;
    if (valid_out !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_async: valid_out=%b want 0 right after reset", valid_out);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, ri, vo, res, fl);
      compared++;
      if (vo !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_stale[%0d]: valid_out=%b res=%h want no output", c, vo, res);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
